// File: rtl/alu_seq_if.sv
// alu_seq_if -- operand/control/status bundle for alu_seq.
//   master (datapath/bench): drives operands, capture enables, opcode,
//                            start and output-register controls;
//                            observes busy, done and flags.
//   slave  (alu_seq)       : the reverse.
// The tri-state result bus OUT_o is a plain port on alu_seq, not part of
// this bundle, so that the high-Z driver sits directly on a module port.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] IN1_i;
    logic [WIDTH-1:0] IN2_i;
    logic             IN1_en;
    logic             IN2_en;
    logic [3:0]       OpControl;
    logic             start;
    logic             OUT_reg_en;
    logic             OUT_en;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output IN1_i, IN2_i, IN1_en, IN2_en, OpControl, start, OUT_reg_en, OUT_en,
        input  busy, done, flags
    );

    modport slave (
        input  IN1_i, IN2_i, IN1_en, IN2_en, OpControl, start, OUT_reg_en, OUT_en,
        output busy, done, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- clocked ALU with operand registers, registered result/flags,
// iterative shift-add multiplier and tri-state result output.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    alu_seq_if.slave: operands, capture enables, opcode, start,
//          output-register controls in; busy, done, flags {C,Z,N,V} out
//   OUT_o  OUTQ when bus.OUT_en, else high-Z
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] OUT_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NOT = 4'd2,
                           OP_AND = 4'd3, OP_OR  = 4'd4, OP_XOR = 4'd5,
                           OP_XNOR = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8,
                           OP_MUL = 4'd9;

    typedef enum logic {IDLE, MULT} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, res_q, outq;
    logic [3:0]         flags_q;
    logic               done_q;
    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, partial;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res, mul_lo;
    logic               alu_c, alu_v, mul_hi, sh_big, last, cap_ok, mul_go;

    assign mul_go = (state == IDLE) && bus.start && (bus.OpControl == OP_MUL);
    assign last   = (cnt == SW'(WIDTH - 1));
    // Operands are frozen for the whole multiply, including its start edge,
    // so the product always uses the values present before start.
    assign cap_ok = (state == IDLE) && !mul_go;

    // ---------------- single-cycle operations ----------------
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        sh_big  = (b_q >= WIDTH'(WIDTH));
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.OpControl)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];      // borrow: A < B unsigned
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_NOT:  alu_res = ~a_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            // Whole of B is checked so that e.g. B=WIDTH clears the result
            // instead of aliasing to a zero shift.
            OP_SHL:  alu_res = sh_big ? '0 : (a_q << b_q[SW-1:0]);
            OP_SHR:  alu_res = sh_big ? '0 : (a_q >> b_q[SW-1:0]);
            default: alu_res = '0;
        endcase
    end

    // ---------------- multiplier step ----------------
    always_comb begin
        partial = {{WIDTH{1'b0}}, a_q} << cnt;
        acc_nxt = b_q[cnt] ? (acc + partial) : acc;
        mul_lo  = acc_nxt[WIDTH-1:0];
        mul_hi  = |acc_nxt[2*WIDTH-1:WIDTH];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_go) state_nxt = MULT;
            MULT:    if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == MULT);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            outq    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.IN1_en && cap_ok) a_q <= bus.IN1_i;
            if (bus.IN2_en && cap_ok) b_q <= bus.IN2_i;
            // Samples RES before any update on this edge.
            if (bus.OUT_reg_en) outq <= res_q;
            case (state)
                IDLE: begin
                    if (mul_go) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (bus.start) begin
                        res_q   <= alu_res;
                        flags_q <= {alu_c, (alu_res == '0), alu_res[MSB], alu_v};
                        done_q  <= 1'b1;
                    end
                end
                MULT: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        res_q   <= mul_lo;
                        flags_q <= {mul_hi, (mul_lo == '0), mul_lo[MSB], mul_hi};
                        done_q  <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done  = done_q;
    assign bus.flags = flags_q;
    assign OUT_o     = bus.OUT_en ? outq : 'z;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    wire  [W-1:0] out_o;
    int           checks = 0;
    int           errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .OUT_o (out_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.IN1_i  = a;
        bus.IN2_i  = b;
        bus.IN1_en = 1'b1;
        bus.IN2_en = 1'b1;
        tick();
        bus.IN1_en = 1'b0;
        bus.IN2_en = 1'b0;
    endtask

    // Single-cycle op: done right after the start edge, gone one edge later.
    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        bus.OpControl = op;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_flags"}, bus.flags, exp_flags);
        bus.OUT_reg_en = 1'b1;
        tick();
        bus.OUT_reg_en = 1'b0;
        chk({tag, "_done_drop"}, bus.done, 0);
        chk({tag, "_res"}, out_o, exp_res);
    endtask

    task automatic do_mul(input string tag, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input bit inject);
        int n = 0;
        int guard = 0;
        bus.OpControl = 4'd9;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!bus.done && guard < 40) begin
            if (bus.busy) n++;
            if (inject && n == 3) begin
                bus.IN1_i  = 16'h5555;
                bus.IN1_en = 1'b1;
                bus.start  = 1'b1;
            end
            tick();
            bus.IN1_en = 1'b0;
            bus.start  = 1'b0;
            guard++;
        end
        chk({tag, "_timeout"}, bus.done, 1);
        chk({tag, "_busy_cycles"}, n, W);
        chk({tag, "_busy_end"}, bus.busy, 0);
        chk({tag, "_flags"}, bus.flags, exp_flags);
        bus.OUT_reg_en = 1'b1;
        tick();
        bus.OUT_reg_en = 1'b0;
        chk({tag, "_done_drop"}, bus.done, 0);
        chk({tag, "_res"}, out_o, exp_res);
    endtask

    initial begin
        bit saw_done;
        reset          = 1'b1;
        bus.IN1_i      = '0;
        bus.IN2_i      = '0;
        bus.IN1_en     = 1'b0;
        bus.IN2_en     = 1'b0;
        bus.OpControl  = '0;
        bus.start      = 1'b0;
        bus.OUT_reg_en = 1'b0;
        bus.OUT_en     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", bus.flags, 0);
        chk("rst_out", out_o, 0);

        // flags = {C,Z,N,V}
        load(16'hFFFF, 16'h0001); do_op("add_wrap", 4'd0, 16'h0000, 4'b1100);
        load(16'h8000, 16'h0001); do_op("sub_ovf",  4'd1, 16'h7FFF, 4'b0001);
        load(16'h0001, 16'h0002); do_op("sub_brw",  4'd1, 16'hFFFF, 4'b1010);
        load(16'h0001, 16'h000F); do_op("shl15",    4'd7, 16'h8000, 4'b0010);
        load(16'h8000, 16'h0010); do_op("shr16",    4'd8, 16'h0000, 4'b0100);
        do_op("op12", 4'd12, 16'h0000, 4'b0100);
        load(16'h00F0, 16'h0FF0); do_op("xnor",     4'd6, 16'hF0FF, 4'b0010);

        load(16'h0012, 16'h0034); do_mul("mul_a", 16'h03A8, 4'b0000, 1'b1);
        load(16'h1000, 16'h0010); do_mul("mul_hi", 16'h0000, 4'b1101, 1'b0);

        // Back-to-back single-cycle ops: start held over done.
        load(16'h0001, 16'h0001);
        bus.OpControl = 4'd0;
        bus.start     = 1'b1;
        tick();
        chk("b2b_add_flags", bus.flags, 4'b0000);
        bus.OpControl = 4'd1;
        tick();
        bus.start = 1'b0;
        chk("b2b_sub_done", bus.done, 1);
        chk("b2b_sub_flags", bus.flags, 4'b0100);
        tick();

        // Abort a multiply with reset at its fifth busy cycle.
        load(16'h0003, 16'h0004); do_op("add_pre", 4'd0, 16'h0007, 4'b0000);
        load(16'h1000, 16'h0010);
        bus.OpControl = 4'd9;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_flags", bus.flags, 0);
        saw_done = 1'b0;
        repeat (20) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        bus.OUT_reg_en = 1'b1;
        tick();
        bus.OUT_reg_en = 1'b0;
        chk("abort_res", out_o, 0);

        // OUT_reg_en coinciding with done captures the previous RES.
        load(16'h0005, 16'h0006); do_op("add_b", 4'd0, 16'h000B, 4'b0000);
        load(16'h0002, 16'h0003);
        bus.OpControl  = 4'd0;
        bus.start      = 1'b1;
        bus.OUT_reg_en = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("outq_done", bus.done, 1);
        chk("outq_old", out_o, 16'h000B);
        tick();
        bus.OUT_reg_en = 1'b0;
        chk("outq_new", out_o, 16'h0005);
        bus.OUT_en = 1'b0;
        #1;
        chk("out_released", (out_o === 16'h0005) ? 1 : 0, 0);
        bus.OUT_en = 1'b1;
        #1;
        chk("out_driven", out_o, 16'h0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
